// File: rtl/csr_irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csr_irq_ctrl_pkg
// Brief    : CSR addresses, op/state encodings and interrupt bit-map helpers.
// Revision : 1.0 - initial release
// ============================================================================
package csr_irq_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH= 12'hB82;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    localparam logic [4:0] CAUSE_EXT   = 5'd11;
    localparam logic [4:0] CAUSE_TIMER = 5'd7;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_MRET = 2'd2,
        ST_WFI  = 2'd3
    } fsm_state_e;

    // Source k lives at mie/mip bit 11 (ext), 7 (timer) or 14+k (platform).
    function automatic int irq_bit(input int k);
        if (k == 0)      return 11;
        else if (k == 1) return 7;
        else             return 14 + k;
    endfunction

    function automatic logic [4:0] irq_code(input int k);
        return 5'(irq_bit(k));
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_irq_ctrl_if
// Brief    : Pipeline <-> CSR/interrupt unit signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface csr_irq_ctrl_if;
    logic        csr_valid;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [4:0]  csr_rs1_idx;
    logic [31:0] csr_wdata;
    logic        mret;
    logic        wfi;
    logic [31:0] pc_in;
    logic        retire;
    logic        pipe_stall;
    logic [31:0] csr_rdata;
    logic        trap_flag;
    logic [31:0] trap_pc;
    logic        mret_flag;
    logic [31:0] mepc_out;
    logic        wfi_stall;

    modport master (
        output csr_valid, csr_funct3, csr_addr, csr_rs1_idx, csr_wdata,
               mret, wfi, pc_in, retire, pipe_stall,
        input  csr_rdata, trap_flag, trap_pc, mret_flag, mepc_out, wfi_stall
    );

    modport slave (
        input  csr_valid, csr_funct3, csr_addr, csr_rs1_idx, csr_wdata,
               mret, wfi, pc_in, retire, pipe_stall,
        output csr_rdata, trap_flag, trap_pc, mret_flag, mepc_out, wfi_stall
    );
endinterface
`default_nettype wire

// File: rtl/csr_irq_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : csr_irq_arbiter
// Brief    : Fixed-priority encoder, lowest source index wins.
// Revision : 1.0 - initial release
// ============================================================================
module csr_irq_arbiter
    import csr_irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 2
) (
    input  wire logic [NUM_IRQ-1:0] req,
    output logic                    pending,
    output logic [4:0]              code
);

    always_comb begin
        pending = |req;
        code    = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (req[k]) code = irq_code(k);
        end
    end

endmodule
`default_nettype wire

// File: rtl/csr_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csr_irq_ctrl
// Brief    : Machine-mode CSR file, counters and prioritised interrupt FSM.
//            Optional vectored mtvec enabled by CSR_VECTORED_MODE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module csr_irq_ctrl
    import csr_irq_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ     = 2,
    parameter logic [31:0] MTVEC_RESET = 32'h0001_0000
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [NUM_IRQ-1:0] irq,
    csr_irq_ctrl_if.slave           bus
);

    fsm_state_e        r_state, w_next_state;
    logic [NUM_IRQ-1:0] r_mip_src, r_mie_src, w_mie_new;
    logic              r_mie_bit, r_mpie;
    logic [31:0]       r_mepc, r_mcause, r_mtvec, r_wfi_pc;
    logic [63:0]       r_mcycle, r_minstret, w_mcycle_nxt, w_minstret_nxt;

    logic [31:0]       w_mie_word, w_mip_word, w_csr_old, w_csr_new, w_src_data;
    logic              w_pending, w_csr_we;
    logic [4:0]        w_code;
    logic              w_enter_trap, w_enter_mret, w_enter_wfi;
    logic [31:0]       w_trap_epc, w_mtvec_base;
    csr_op_e           w_op;

    csr_irq_arbiter #(.NUM_IRQ(NUM_IRQ)) u_arbiter (
        .req     (r_mip_src & r_mie_src),
        .pending (w_pending),
        .code    (w_code)
    );

    always_comb begin
        w_mie_word = '0;
        w_mip_word = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            w_mie_word[irq_bit(k)] = r_mie_src[k];
            w_mip_word[irq_bit(k)] = r_mip_src[k];
        end
    end

    always_comb begin
        w_mie_new = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            w_mie_new[k] = w_csr_new[irq_bit(k)];
        end
    end

    always_comb begin
        case (bus.csr_addr)
            CSR_MSTATUS:   w_csr_old = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie_bit, 3'd0};
            CSR_MIE:       w_csr_old = w_mie_word;
            CSR_MTVEC:     w_csr_old = r_mtvec;
            CSR_MEPC:      w_csr_old = r_mepc;
            CSR_MCAUSE:    w_csr_old = r_mcause;
            CSR_MIP:       w_csr_old = w_mip_word;
            CSR_MCYCLE,
            CSR_CYCLE:     w_csr_old = r_mcycle[31:0];
            CSR_MCYCLEH,
            CSR_CYCLEH:    w_csr_old = r_mcycle[63:32];
            CSR_MINSTRET,
            CSR_INSTRET:   w_csr_old = r_minstret[31:0];
            CSR_MINSTRETH,
            CSR_INSTRETH:  w_csr_old = r_minstret[63:32];
            default:       w_csr_old = '0;
        endcase
    end

    assign w_op       = csr_op_e'(bus.csr_funct3[1:0]);
    assign w_src_data = bus.csr_funct3[2] ? {27'd0, bus.csr_rs1_idx} : bus.csr_wdata;

    always_comb begin
        case (w_op)
            CSR_OP_RW: w_csr_new = w_src_data;
            CSR_OP_RS: w_csr_new = w_csr_old | w_src_data;
            CSR_OP_RC: w_csr_new = w_csr_old & ~w_src_data;
            default:   w_csr_new = w_csr_old;
        endcase
    end

    // A trap taken this cycle flushes the CSR instruction, so its write is dropped.
    assign w_csr_we = bus.csr_valid && (r_state == ST_RUN) && !bus.pipe_stall && !w_enter_trap &&
                      (w_op != CSR_OP_NONE) && ((w_op == CSR_OP_RW) || (bus.csr_rs1_idx != 5'd0));

    always_comb begin
        w_next_state = r_state;
        w_enter_trap = 1'b0;
        w_enter_mret = 1'b0;
        w_enter_wfi  = 1'b0;
        w_trap_epc   = bus.pc_in;
        if (!bus.pipe_stall) begin
            case (r_state)
                ST_RUN: begin
                    if (r_mie_bit && w_pending) begin
                        w_next_state = ST_TRAP;
                        w_enter_trap = 1'b1;
                    end else if (bus.mret) begin
                        w_next_state = ST_MRET;
                        w_enter_mret = 1'b1;
                    end else if (bus.wfi && !w_pending) begin
                        w_next_state = ST_WFI;
                        w_enter_wfi  = 1'b1;
                    end
                end
                ST_WFI: begin
                    if (w_pending && r_mie_bit) begin
                        w_next_state = ST_TRAP;
                        w_enter_trap = 1'b1;
                        w_trap_epc   = r_wfi_pc + 32'd4;
                    end else if (w_pending) begin
                        w_next_state = ST_RUN;
                    end
                end
                default: w_next_state = ST_RUN;
            endcase
        end
    end

    // Machine counter addresses accept writes so software can preload them.
    always_comb begin
        w_mcycle_nxt   = r_mcycle + 64'd1;
        w_minstret_nxt = r_minstret + {63'd0, bus.retire & ~bus.pipe_stall};
        if (w_csr_we) begin
            case (bus.csr_addr)
                CSR_MCYCLE:    w_mcycle_nxt[31:0]    = w_csr_new;
                CSR_MCYCLEH:   w_mcycle_nxt[63:32]   = w_csr_new;
                CSR_MINSTRET:  w_minstret_nxt[31:0]  = w_csr_new;
                CSR_MINSTRETH: w_minstret_nxt[63:32] = w_csr_new;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_mip_src  <= '0;
            r_mie_src  <= '0;
            r_mie_bit  <= 1'b0;
            r_mpie     <= 1'b0;
            r_mepc     <= '0;
            r_mcause   <= '0;
`ifdef CSR_VECTORED_MODE_EN
            r_mtvec    <= MTVEC_RESET;
`else
            r_mtvec    <= {MTVEC_RESET[31:2], 2'b00};
`endif
            r_wfi_pc   <= '0;
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            r_state    <= w_next_state;
            r_mip_src  <= irq;
            r_mcycle   <= w_mcycle_nxt;
            r_minstret <= w_minstret_nxt;
            if (w_enter_trap) begin
                r_mepc    <= w_trap_epc;
                r_mcause  <= {1'b1, 26'd0, w_code};
                r_mpie    <= r_mie_bit;
                r_mie_bit <= 1'b0;
            end else if (w_enter_mret) begin
                r_mie_bit <= r_mpie;
                r_mpie    <= 1'b1;
            end
            if (w_enter_wfi) r_wfi_pc <= bus.pc_in;
            if (w_csr_we) begin
                case (bus.csr_addr)
                    CSR_MSTATUS: begin
                        r_mie_bit <= w_csr_new[3];
                        r_mpie    <= w_csr_new[7];
                    end
                    CSR_MIE:    r_mie_src <= w_mie_new;
`ifdef CSR_VECTORED_MODE_EN
                    CSR_MTVEC:  r_mtvec   <= w_csr_new;
`else
                    CSR_MTVEC:  r_mtvec   <= {w_csr_new[31:2], 2'b00};
`endif
                    CSR_MEPC:   r_mepc    <= {w_csr_new[31:2], 2'b00};
                    CSR_MCAUSE: r_mcause  <= w_csr_new;
                    default: ;
                endcase
            end
        end
    end

    assign w_mtvec_base = {r_mtvec[31:2], 2'b00};
`ifdef CSR_VECTORED_MODE_EN
    assign bus.trap_pc = (r_mtvec[1:0] == 2'b01) ? w_mtvec_base + {25'd0, r_mcause[4:0], 2'b00}
                                                 : w_mtvec_base;
`else
    assign bus.trap_pc = w_mtvec_base;
`endif

    assign bus.csr_rdata = w_csr_old;
    assign bus.trap_flag = (r_state == ST_TRAP);
    assign bus.mret_flag = (r_state == ST_MRET);
    assign bus.wfi_stall = (r_state == ST_WFI);
    assign bus.mepc_out  = r_mepc;

endmodule
`default_nettype wire

// File: tb/tb_csr_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_irq_ctrl
// Brief    : Directed self-checking bench for csr_irq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_irq_ctrl;
    localparam int NUM_IRQ = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NUM_IRQ-1:0] irq = '0;
    int                 checks = 0;
    int                 errors = 0;

    csr_irq_ctrl_if bus ();

    csr_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .MTVEC_RESET(32'h0001_0000)) dut (
        .clk (clk),
        .rst (rst),
        .irq (irq),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_csr(input logic [11:0] a, output logic [31:0] d);
        bus.csr_addr = a;
        #1;
        d = bus.csr_rdata;
    endtask

    task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                          input logic [31:0] wd, output logic [31:0] old);
        bus.csr_valid   = 1'b1;
        bus.csr_funct3  = f3;
        bus.csr_addr    = a;
        bus.csr_rs1_idx = idx;
        bus.csr_wdata   = wd;
        #1;
        old = bus.csr_rdata;
        tick();
        bus.csr_valid  = 1'b0;
        bus.csr_funct3 = 3'b000;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++; if (bus.trap_flag !== 1'b0 || bus.mret_flag !== 1'b0 || bus.wfi_stall !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got %b%b%b expected 000", bus.trap_flag, bus.mret_flag, bus.wfi_stall); end
        checks++; if (bus.mepc_out !== 32'h0) begin
            errors++; $display("FAIL reset_mepc: got %h expected 00000000", bus.mepc_out); end
        read_csr(12'h305, d);
        checks++; if (d !== 32'h0001_0000) begin
            errors++; $display("FAIL reset_mtvec: got %h expected 00010000", d); end
        read_csr(12'h300, d);
        checks++; if (d !== 32'h0000_1800) begin
            errors++; $display("FAIL reset_mstatus: got %h expected 00001800", d); end
        read_csr(12'h304, d);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL reset_mie: got %h expected 00000000", d); end
        read_csr(12'h342, d);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL reset_mcause: got %h expected 00000000", d); end
    endtask

    task automatic test_trap();
        logic [31:0] d;
        csr_op(3'b001, 12'h305, 5'd1, 32'h0000_2000, d);
        checks++; if (d !== 32'h0001_0000) begin
            errors++; $display("FAIL csrrw_old_mtvec: got %h expected 00010000", d); end
        csr_op(3'b010, 12'h304, 5'd1, 32'h0000_0880, d);
        csr_op(3'b110, 12'h300, 5'd8, 32'h0, d);
        bus.pc_in = 32'h100;
        irq = 2'b10;
        tick();
        checks++; if (bus.trap_flag !== 1'b0) begin
            errors++; $display("FAIL trap_early: got %b expected 0", bus.trap_flag); end
        tick();
        checks++; if (bus.trap_flag !== 1'b1) begin
            errors++; $display("FAIL trap_flag: got %b expected 1", bus.trap_flag); end
        checks++; if (bus.trap_pc !== 32'h2000) begin
            errors++; $display("FAIL trap_pc: got %h expected 00002000", bus.trap_pc); end
        checks++; if (bus.mepc_out !== 32'h100) begin
            errors++; $display("FAIL trap_mepc: got %h expected 00000100", bus.mepc_out); end
        read_csr(12'h342, d);
        checks++; if (d !== 32'h8000_0007) begin
            errors++; $display("FAIL trap_mcause: got %h expected 80000007", d); end
        read_csr(12'h300, d);
        checks++; if (d !== 32'h0000_1880) begin
            errors++; $display("FAIL trap_mstatus: got %h expected 00001880", d); end
        irq = 2'b00;
        tick();
        checks++; if (bus.trap_flag !== 1'b0) begin
            errors++; $display("FAIL trap_pulse: got %b expected 0", bus.trap_flag); end
        tick();
    endtask

    task automatic test_priority_mret();
        logic [31:0] d;
        csr_op(3'b110, 12'h300, 5'd8, 32'h0, d);
        irq = 2'b11;
        tick();
        tick();
        checks++; if (bus.trap_flag !== 1'b1) begin
            errors++; $display("FAIL prio_trap: got %b expected 1", bus.trap_flag); end
        read_csr(12'h342, d);
        checks++; if (d !== 32'h8000_000B) begin
            errors++; $display("FAIL prio_mcause: got %h expected 8000000b", d); end
        irq = 2'b00;
        tick();
        tick();
        bus.mret = 1'b1;
        tick();
        bus.mret = 1'b0;
        checks++; if (bus.mret_flag !== 1'b1) begin
            errors++; $display("FAIL mret_flag: got %b expected 1", bus.mret_flag); end
        checks++; if (bus.mepc_out !== 32'h100) begin
            errors++; $display("FAIL mret_pc: got %h expected 00000100", bus.mepc_out); end
        read_csr(12'h300, d);
        checks++; if (d !== 32'h0000_1888) begin
            errors++; $display("FAIL mret_mstatus: got %h expected 00001888", d); end
        tick();
        checks++; if (bus.mret_flag !== 1'b0) begin
            errors++; $display("FAIL mret_pulse: got %b expected 0", bus.mret_flag); end
    endtask

    task automatic test_wfi();
        logic [31:0] d;
        csr_op(3'b111, 12'h300, 5'd8, 32'h0, d);
        bus.pc_in = 32'h200;
        bus.wfi   = 1'b1;
        tick();
        checks++; if (bus.wfi_stall !== 1'b1) begin
            errors++; $display("FAIL wfi_enter: got %b expected 1", bus.wfi_stall); end
        tick();
        irq = 2'b01;
        tick();
        checks++; if (bus.wfi_stall !== 1'b1) begin
            errors++; $display("FAIL wfi_hold: got %b expected 1", bus.wfi_stall); end
        tick();
        checks++; if (bus.wfi_stall !== 1'b0 || bus.trap_flag !== 1'b0) begin
            errors++; $display("FAIL wfi_resume: got stall %b trap %b expected 0 0", bus.wfi_stall, bus.trap_flag); end
        bus.wfi = 1'b0;
        irq     = 2'b00;
        tick();
        tick();
        csr_op(3'b110, 12'h300, 5'd8, 32'h0, d);
        bus.wfi = 1'b1;
        tick();
        checks++; if (bus.wfi_stall !== 1'b1) begin
            errors++; $display("FAIL wfi_enter2: got %b expected 1", bus.wfi_stall); end
        irq = 2'b01;
        tick();
        tick();
        checks++; if (bus.trap_flag !== 1'b1 || bus.mepc_out !== 32'h204) begin
            errors++; $display("FAIL wfi_trap: got trap %b mepc %h expected 1 00000204", bus.trap_flag, bus.mepc_out); end
        bus.wfi = 1'b0;
        irq     = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_csr_rs_rc();
        logic [31:0] d;
        csr_op(3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, d);
        checks++; if (d !== 32'h0000_1880) begin
            errors++; $display("FAIL rs0_read: got %h expected 00001880", d); end
        read_csr(12'h300, d);
        checks++; if (d !== 32'h0000_1880) begin
            errors++; $display("FAIL rs0_nowrite: got %h expected 00001880", d); end
        csr_op(3'b011, 12'h304, 5'd5, 32'h0000_0080, d);
        checks++; if (d !== 32'h0000_0880) begin
            errors++; $display("FAIL rc_old: got %h expected 00000880", d); end
        read_csr(12'h304, d);
        checks++; if (d !== 32'h0000_0800) begin
            errors++; $display("FAIL rc_mie: got %h expected 00000800", d); end
    endtask

    task automatic test_vectored_counters();
        logic [31:0] d;
        logic [31:0] exp_mtvec, exp_tpc;
`ifdef CSR_VECTORED_MODE_EN
        exp_mtvec = 32'h0000_2001;
        exp_tpc   = 32'h0000_201C;
`else
        exp_mtvec = 32'h0000_2000;
        exp_tpc   = 32'h0000_2000;
`endif
        csr_op(3'b001, 12'h305, 5'd1, 32'h0000_2001, d);
        read_csr(12'h305, d);
        checks++; if (d !== exp_mtvec) begin
            errors++; $display("FAIL mtvec_mode: got %h expected %h", d, exp_mtvec); end
        csr_op(3'b010, 12'h304, 5'd1, 32'h0000_0080, d);
        csr_op(3'b110, 12'h300, 5'd8, 32'h0, d);
        irq = 2'b10;
        tick();
        tick();
        checks++; if (bus.trap_flag !== 1'b1 || bus.trap_pc !== exp_tpc) begin
            errors++; $display("FAIL vec_trap_pc: got trap %b pc %h expected 1 %h", bus.trap_flag, bus.trap_pc, exp_tpc); end
        irq = 2'b00;
        tick();
        tick();
        csr_op(3'b001, 12'hB80, 5'd1, 32'h0, d);
        csr_op(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF, d);
        read_csr(12'hB00, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL mcycle_preload: got %h expected ffffffff", d); end
        tick();
        read_csr(12'hB80, d);
        checks++; if (d !== 32'h1) begin
            errors++; $display("FAIL mcycleh_carry: got %h expected 00000001", d); end
        read_csr(12'hC00, d);
        checks++; if (d !== 32'h0) begin
            errors++; $display("FAIL cycle_low_wrap: got %h expected 00000000", d); end
        bus.retire = 1'b1;
        tick();
        bus.pipe_stall = 1'b1;
        tick();
        bus.pipe_stall = 1'b0;
        tick();
        bus.retire = 1'b0;
        read_csr(12'hC02, d);
        checks++; if (d !== 32'h2) begin
            errors++; $display("FAIL minstret_count: got %h expected 00000002", d); end
    endtask

    initial begin
        bus.csr_valid   = 1'b0;
        bus.csr_funct3  = 3'b000;
        bus.csr_addr    = 12'h000;
        bus.csr_rs1_idx = 5'd0;
        bus.csr_wdata   = 32'h0;
        bus.mret        = 1'b0;
        bus.wfi         = 1'b0;
        bus.pc_in       = 32'h0;
        bus.retire      = 1'b0;
        bus.pipe_stall  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        test_reset();
        test_trap();
        test_priority_mret();
        test_wfi();
        test_csr_rs_rc();
        test_vectored_counters();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
